// File: rtl/aes_pkg.sv
// Shared widths, FSM encoding and parameter legality check for the
// iterative AES InvSubBytes block.
package aes_pkg;

    localparam int BYTE_W    = 8;
    localparam int STATE_W   = 128;
    localparam int NUM_BYTES = STATE_W / BYTE_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } fsm_state_e;

    function automatic bit bpc_legal(input int bpc);
        return (bpc == 1) || (bpc == 2) || (bpc == 4) || (bpc == 8) || (bpc == 16);
    endfunction

endpackage

// File: rtl/inv_sbox.sv
// FIPS-197 inverse S-box, one byte, purely combinational.
module inv_sbox (
    input  logic [7:0] in_byte_i,
    output logic [7:0] out_byte_o
);

    always_comb begin
        case (in_byte_i)
            8'h00: out_byte_o = 8'h52; 8'h01: out_byte_o = 8'h09; 8'h02: out_byte_o = 8'h6a; 8'h03: out_byte_o = 8'hd5; 8'h04: out_byte_o = 8'h30; 8'h05: out_byte_o = 8'h36; 8'h06: out_byte_o = 8'ha5; 8'h07: out_byte_o = 8'h38;
            8'h08: out_byte_o = 8'hbf; 8'h09: out_byte_o = 8'h40; 8'h0a: out_byte_o = 8'ha3; 8'h0b: out_byte_o = 8'h9e; 8'h0c: out_byte_o = 8'h81; 8'h0d: out_byte_o = 8'hf3; 8'h0e: out_byte_o = 8'hd7; 8'h0f: out_byte_o = 8'hfb;
            8'h10: out_byte_o = 8'h7c; 8'h11: out_byte_o = 8'he3; 8'h12: out_byte_o = 8'h39; 8'h13: out_byte_o = 8'h82; 8'h14: out_byte_o = 8'h9b; 8'h15: out_byte_o = 8'h2f; 8'h16: out_byte_o = 8'hff; 8'h17: out_byte_o = 8'h87;
            8'h18: out_byte_o = 8'h34; 8'h19: out_byte_o = 8'h8e; 8'h1a: out_byte_o = 8'h43; 8'h1b: out_byte_o = 8'h44; 8'h1c: out_byte_o = 8'hc4; 8'h1d: out_byte_o = 8'hde; 8'h1e: out_byte_o = 8'he9; 8'h1f: out_byte_o = 8'hcb;
            8'h20: out_byte_o = 8'h54; 8'h21: out_byte_o = 8'h7b; 8'h22: out_byte_o = 8'h94; 8'h23: out_byte_o = 8'h32; 8'h24: out_byte_o = 8'ha6; 8'h25: out_byte_o = 8'hc2; 8'h26: out_byte_o = 8'h23; 8'h27: out_byte_o = 8'h3d;
            8'h28: out_byte_o = 8'hee; 8'h29: out_byte_o = 8'h4c; 8'h2a: out_byte_o = 8'h95; 8'h2b: out_byte_o = 8'h0b; 8'h2c: out_byte_o = 8'h42; 8'h2d: out_byte_o = 8'hfa; 8'h2e: out_byte_o = 8'hc3; 8'h2f: out_byte_o = 8'h4e;
            8'h30: out_byte_o = 8'h08; 8'h31: out_byte_o = 8'h2e; 8'h32: out_byte_o = 8'ha1; 8'h33: out_byte_o = 8'h66; 8'h34: out_byte_o = 8'h28; 8'h35: out_byte_o = 8'hd9; 8'h36: out_byte_o = 8'h24; 8'h37: out_byte_o = 8'hb2;
            8'h38: out_byte_o = 8'h76; 8'h39: out_byte_o = 8'h5b; 8'h3a: out_byte_o = 8'ha2; 8'h3b: out_byte_o = 8'h49; 8'h3c: out_byte_o = 8'h6d; 8'h3d: out_byte_o = 8'h8b; 8'h3e: out_byte_o = 8'hd1; 8'h3f: out_byte_o = 8'h25;
            8'h40: out_byte_o = 8'h72; 8'h41: out_byte_o = 8'hf8; 8'h42: out_byte_o = 8'hf6; 8'h43: out_byte_o = 8'h64; 8'h44: out_byte_o = 8'h86; 8'h45: out_byte_o = 8'h68; 8'h46: out_byte_o = 8'h98; 8'h47: out_byte_o = 8'h16;
            8'h48: out_byte_o = 8'hd4; 8'h49: out_byte_o = 8'ha4; 8'h4a: out_byte_o = 8'h5c; 8'h4b: out_byte_o = 8'hcc; 8'h4c: out_byte_o = 8'h5d; 8'h4d: out_byte_o = 8'h65; 8'h4e: out_byte_o = 8'hb6; 8'h4f: out_byte_o = 8'h92;
            8'h50: out_byte_o = 8'h6c; 8'h51: out_byte_o = 8'h70; 8'h52: out_byte_o = 8'h48; 8'h53: out_byte_o = 8'h50; 8'h54: out_byte_o = 8'hfd; 8'h55: out_byte_o = 8'hed; 8'h56: out_byte_o = 8'hb9; 8'h57: out_byte_o = 8'hda;
            8'h58: out_byte_o = 8'h5e; 8'h59: out_byte_o = 8'h15; 8'h5a: out_byte_o = 8'h46; 8'h5b: out_byte_o = 8'h57; 8'h5c: out_byte_o = 8'ha7; 8'h5d: out_byte_o = 8'h8d; 8'h5e: out_byte_o = 8'h9d; 8'h5f: out_byte_o = 8'h84;
            8'h60: out_byte_o = 8'h90; 8'h61: out_byte_o = 8'hd8; 8'h62: out_byte_o = 8'hab; 8'h63: out_byte_o = 8'h00; 8'h64: out_byte_o = 8'h8c; 8'h65: out_byte_o = 8'hbc; 8'h66: out_byte_o = 8'hd3; 8'h67: out_byte_o = 8'h0a;
            8'h68: out_byte_o = 8'hf7; 8'h69: out_byte_o = 8'he4; 8'h6a: out_byte_o = 8'h58; 8'h6b: out_byte_o = 8'h05; 8'h6c: out_byte_o = 8'hb8; 8'h6d: out_byte_o = 8'hb3; 8'h6e: out_byte_o = 8'h45; 8'h6f: out_byte_o = 8'h06;
            8'h70: out_byte_o = 8'hd0; 8'h71: out_byte_o = 8'h2c; 8'h72: out_byte_o = 8'h1e; 8'h73: out_byte_o = 8'h8f; 8'h74: out_byte_o = 8'hca; 8'h75: out_byte_o = 8'h3f; 8'h76: out_byte_o = 8'h0f; 8'h77: out_byte_o = 8'h02;
            8'h78: out_byte_o = 8'hc1; 8'h79: out_byte_o = 8'haf; 8'h7a: out_byte_o = 8'hbd; 8'h7b: out_byte_o = 8'h03; 8'h7c: out_byte_o = 8'h01; 8'h7d: out_byte_o = 8'h13; 8'h7e: out_byte_o = 8'h8a; 8'h7f: out_byte_o = 8'h6b;
            8'h80: out_byte_o = 8'h3a; 8'h81: out_byte_o = 8'h91; 8'h82: out_byte_o = 8'h11; 8'h83: out_byte_o = 8'h41; 8'h84: out_byte_o = 8'h4f; 8'h85: out_byte_o = 8'h67; 8'h86: out_byte_o = 8'hdc; 8'h87: out_byte_o = 8'hea;
            8'h88: out_byte_o = 8'h97; 8'h89: out_byte_o = 8'hf2; 8'h8a: out_byte_o = 8'hcf; 8'h8b: out_byte_o = 8'hce; 8'h8c: out_byte_o = 8'hf0; 8'h8d: out_byte_o = 8'hb4; 8'h8e: out_byte_o = 8'he6; 8'h8f: out_byte_o = 8'h73;
            8'h90: out_byte_o = 8'h96; 8'h91: out_byte_o = 8'hac; 8'h92: out_byte_o = 8'h74; 8'h93: out_byte_o = 8'h22; 8'h94: out_byte_o = 8'he7; 8'h95: out_byte_o = 8'had; 8'h96: out_byte_o = 8'h35; 8'h97: out_byte_o = 8'h85;
            8'h98: out_byte_o = 8'he2; 8'h99: out_byte_o = 8'hf9; 8'h9a: out_byte_o = 8'h37; 8'h9b: out_byte_o = 8'he8; 8'h9c: out_byte_o = 8'h1c; 8'h9d: out_byte_o = 8'h75; 8'h9e: out_byte_o = 8'hdf; 8'h9f: out_byte_o = 8'h6e;
            8'ha0: out_byte_o = 8'h47; 8'ha1: out_byte_o = 8'hf1; 8'ha2: out_byte_o = 8'h1a; 8'ha3: out_byte_o = 8'h71; 8'ha4: out_byte_o = 8'h1d; 8'ha5: out_byte_o = 8'h29; 8'ha6: out_byte_o = 8'hc5; 8'ha7: out_byte_o = 8'h89;
            8'ha8: out_byte_o = 8'h6f; 8'ha9: out_byte_o = 8'hb7; 8'haa: out_byte_o = 8'h62; 8'hab: out_byte_o = 8'h0e; 8'hac: out_byte_o = 8'haa; 8'had: out_byte_o = 8'h18; 8'hae: out_byte_o = 8'hbe; 8'haf: out_byte_o = 8'h1b;
            8'hb0: out_byte_o = 8'hfc; 8'hb1: out_byte_o = 8'h56; 8'hb2: out_byte_o = 8'h3e; 8'hb3: out_byte_o = 8'h4b; 8'hb4: out_byte_o = 8'hc6; 8'hb5: out_byte_o = 8'hd2; 8'hb6: out_byte_o = 8'h79; 8'hb7: out_byte_o = 8'h20;
            8'hb8: out_byte_o = 8'h9a; 8'hb9: out_byte_o = 8'hdb; 8'hba: out_byte_o = 8'hc0; 8'hbb: out_byte_o = 8'hfe; 8'hbc: out_byte_o = 8'h78; 8'hbd: out_byte_o = 8'hcd; 8'hbe: out_byte_o = 8'h5a; 8'hbf: out_byte_o = 8'hf4;
            8'hc0: out_byte_o = 8'h1f; 8'hc1: out_byte_o = 8'hdd; 8'hc2: out_byte_o = 8'ha8; 8'hc3: out_byte_o = 8'h33; 8'hc4: out_byte_o = 8'h88; 8'hc5: out_byte_o = 8'h07; 8'hc6: out_byte_o = 8'hc7; 8'hc7: out_byte_o = 8'h31;
            8'hc8: out_byte_o = 8'hb1; 8'hc9: out_byte_o = 8'h12; 8'hca: out_byte_o = 8'h10; 8'hcb: out_byte_o = 8'h59; 8'hcc: out_byte_o = 8'h27; 8'hcd: out_byte_o = 8'h80; 8'hce: out_byte_o = 8'hec; 8'hcf: out_byte_o = 8'h5f;
            8'hd0: out_byte_o = 8'h60; 8'hd1: out_byte_o = 8'h51; 8'hd2: out_byte_o = 8'h7f; 8'hd3: out_byte_o = 8'ha9; 8'hd4: out_byte_o = 8'h19; 8'hd5: out_byte_o = 8'hb5; 8'hd6: out_byte_o = 8'h4a; 8'hd7: out_byte_o = 8'h0d;
            8'hd8: out_byte_o = 8'h2d; 8'hd9: out_byte_o = 8'he5; 8'hda: out_byte_o = 8'h7a; 8'hdb: out_byte_o = 8'h9f; 8'hdc: out_byte_o = 8'h93; 8'hdd: out_byte_o = 8'hc9; 8'hde: out_byte_o = 8'h9c; 8'hdf: out_byte_o = 8'hef;
            8'he0: out_byte_o = 8'ha0; 8'he1: out_byte_o = 8'he0; 8'he2: out_byte_o = 8'h3b; 8'he3: out_byte_o = 8'h4d; 8'he4: out_byte_o = 8'hae; 8'he5: out_byte_o = 8'h2a; 8'he6: out_byte_o = 8'hf5; 8'he7: out_byte_o = 8'hb0;
            8'he8: out_byte_o = 8'hc8; 8'he9: out_byte_o = 8'heb; 8'hea: out_byte_o = 8'hbb; 8'heb: out_byte_o = 8'h3c; 8'hec: out_byte_o = 8'h83; 8'hed: out_byte_o = 8'h53; 8'hee: out_byte_o = 8'h99; 8'hef: out_byte_o = 8'h61;
            8'hf0: out_byte_o = 8'h17; 8'hf1: out_byte_o = 8'h2b; 8'hf2: out_byte_o = 8'h04; 8'hf3: out_byte_o = 8'h7e; 8'hf4: out_byte_o = 8'hba; 8'hf5: out_byte_o = 8'h77; 8'hf6: out_byte_o = 8'hd6; 8'hf7: out_byte_o = 8'h26;
            8'hf8: out_byte_o = 8'he1; 8'hf9: out_byte_o = 8'h69; 8'hfa: out_byte_o = 8'h14; 8'hfb: out_byte_o = 8'h63; 8'hfc: out_byte_o = 8'h55; 8'hfd: out_byte_o = 8'h21; 8'hfe: out_byte_o = 8'h0c; 8'hff: out_byte_o = 8'h7d;
        endcase
    end

endmodule

// File: rtl/inv_sub_bytes_iter.sv
// Iterative InvSubBytes: substitutes BYTES_PER_CYCLE bytes of the working
// register per cycle, byte 0 (MSB end) first, with a valid/ready handshake.
//
// state   | meaning
// IDLE    | waiting for in_valid; in_ready high
// BUSY    | substituting one chunk per cycle in place
// DONE    | result held on out_state until out_ready
module inv_sub_bytes_iter
    import aes_pkg::*;
#(
    parameter int BYTES_PER_CYCLE = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_state,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_state,
    output logic               busy
);

    localparam int NUM_CHUNKS = NUM_BYTES / BYTES_PER_CYCLE;
    localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam int IDX_W      = $clog2(STATE_W);
    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NUM_CHUNKS - 1);

    generate
        if (!bpc_legal(BYTES_PER_CYCLE)) begin : g_bad_bpc
            $error("inv_sub_bytes_iter: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    fsm_state_e         state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [STATE_W-1:0] work_q;
    logic [STATE_W-1:0] work_d;
    logic               out_valid_q;
    logic               busy_q;

    logic [IDX_W-1:0]   byte_lsb [BYTES_PER_CYCLE];
    logic [BYTE_W-1:0]  sbox_in  [BYTES_PER_CYCLE];
    logic [BYTE_W-1:0]  sbox_out [BYTES_PER_CYCLE];

    // Byte j sits at bits [STATE_W-1-8j -: 8], so its LSB is STATE_W-8(j+1).
    always_comb begin
        for (int k = 0; k < BYTES_PER_CYCLE; k++) begin
            byte_lsb[k] = IDX_W'(STATE_W - BYTE_W * (int'(cnt_q) * BYTES_PER_CYCLE + k + 1));
        end
    end

    always_comb begin
        for (int k = 0; k < BYTES_PER_CYCLE; k++) begin
            sbox_in[k] = work_q[byte_lsb[k] +: BYTE_W];
        end
    end

    always_comb begin
        work_d = work_q;
        for (int k = 0; k < BYTES_PER_CYCLE; k++) begin
            work_d[byte_lsb[k] +: BYTE_W] = sbox_out[k];
        end
    end

    generate
        for (genvar k = 0; k < BYTES_PER_CYCLE; k++) begin : g_sbox
            inv_sbox u_inv_sbox (
                .in_byte_i  (sbox_in[k]),
                .out_byte_o (sbox_out[k])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            work_q      <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        work_q  <= in_state;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    work_q <= work_d;
                    if (cnt_q == LAST_CHUNK) begin
                        cnt_q       <= '0;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    // Accepting the next state on the same edge the result leaves avoids a bubble.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (in_valid) begin
                            work_q  <= in_state;
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                            state_q <= ST_BUSY;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    cnt_q       <= '0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign out_valid = out_valid_q;
    assign out_state = work_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Directed bench for inv_sub_bytes_iter: main instance at BPC=4 plus
// BPC 1/2/8/16 instances for the round-trip and latency checks.
module tb_inv_sub_bytes_iter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         busy;

    logic         rt_valid;
    logic [127:0] rt_state;
    logic         rt_ordy;
    logic         rt_rdy  [4];
    logic         rt_ov   [4];
    logic [127:0] rt_os   [4];
    logic         rt_busy [4];

    int checks   = 0;
    int failures = 0;
    logic [7:0] fwd [256];

    always #5 clk = ~clk;

    inv_sub_bytes_iter #(.BYTES_PER_CYCLE(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_state(in_state),
        .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state), .busy(busy)
    );
    inv_sub_bytes_iter #(.BYTES_PER_CYCLE(1)) u_bpc1 (
        .clk(clk), .rst_n(rst_n), .in_valid(rt_valid), .in_ready(rt_rdy[0]), .in_state(rt_state),
        .out_valid(rt_ov[0]), .out_ready(rt_ordy), .out_state(rt_os[0]), .busy(rt_busy[0])
    );
    inv_sub_bytes_iter #(.BYTES_PER_CYCLE(2)) u_bpc2 (
        .clk(clk), .rst_n(rst_n), .in_valid(rt_valid), .in_ready(rt_rdy[1]), .in_state(rt_state),
        .out_valid(rt_ov[1]), .out_ready(rt_ordy), .out_state(rt_os[1]), .busy(rt_busy[1])
    );
    inv_sub_bytes_iter #(.BYTES_PER_CYCLE(8)) u_bpc8 (
        .clk(clk), .rst_n(rst_n), .in_valid(rt_valid), .in_ready(rt_rdy[2]), .in_state(rt_state),
        .out_valid(rt_ov[2]), .out_ready(rt_ordy), .out_state(rt_os[2]), .busy(rt_busy[2])
    );
    inv_sub_bytes_iter #(.BYTES_PER_CYCLE(16)) u_bpc16 (
        .clk(clk), .rst_n(rst_n), .in_valid(rt_valid), .in_ready(rt_rdy[3]), .in_state(rt_state),
        .out_valid(rt_ov[3]), .out_ready(rt_ordy), .out_state(rt_os[3]), .busy(rt_busy[3])
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] sub_fwd(input logic [127:0] s);
        logic [127:0] r;
        logic [127:0] t;
        r = '0;
        t = s;
        for (int i = 0; i < 16; i++) begin
            r = {r[119:0], fwd[t[127:120]]};
            t = t << 8;
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input string tag, input logic [127:0] s);
        chk({tag, "_in_ready"}, {127'd0, in_ready}, 128'd1);
        in_state = s;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            step();
            cyc++;
        end
    endtask

    task automatic pop();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    localparam logic [127:0] KV_IN  = 128'h63007c16_52637c00_16527c63_00160052;
    localparam logic [127:0] KV_EXP = 128'h005201ff_48000152_ff480100_52ff5248;
    localparam logic [127:0] PT     = 128'h00112233_44556677_8899aabb_ccddeeff;

    initial begin
        int lat;
        int rt_lat [4];
        int rt_exp [4];
        logic bad;
        logic [127:0] s, e;

        fwd = '{
            8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
            8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
            8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
            8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
            8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
            8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
            8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
            8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
            8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
            8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
            8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
            8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
            8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
            8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
            8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
            8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
        };

        rst_n = 1'b0; in_valid = 1'b0; in_state = '0; out_ready = 1'b0;
        rt_valid = 1'b0; rt_state = '0; rt_ordy = 1'b0;

        // Reset values, observed while reset is still asserted
        #12;
        chk("rst_in_ready",  {127'd0, in_ready},  128'd1);
        chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
        chk("rst_busy",      {127'd0, busy},      128'd0);
        chk("rst_out_state", out_state,           128'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_in_ready", {127'd0, in_ready}, 128'd1);

        // Zero state: 4-cycle latency, all bytes 0x52
        accept("zero", '0);
        chk("zero_busy",     {127'd0, busy},     128'd1);
        chk("zero_in_ready", {127'd0, in_ready}, 128'd0);
        wait_out(lat);
        chk("zero_latency", 128'(lat), 128'd4);
        chk("zero_result",  out_state, {16{8'h52}});
        pop();
        chk("zero_pop_valid", {127'd0, out_valid}, 128'd0);

        // Byte ordering with distinct values per position, then backpressure
        accept("kv", KV_IN);
        wait_out(lat);
        chk("kv_latency", 128'(lat), 128'd4);
        chk("kv_result",  out_state, KV_EXP);
        in_valid = 1'b1;
        in_state = {16{8'hab}};
        bad = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (!out_valid || out_state !== KV_EXP || in_ready || busy) bad = 1'b1;
        end
        chk("bp_stable", {127'd0, bad}, 128'd0);
        chk("bp_result", out_state, KV_EXP);
        in_valid = 1'b0;
        pop();
        chk("bp_pop_in_ready", {127'd0, in_ready}, 128'd1);
        chk("bp_pop_busy",     {127'd0, busy},     128'd0);

        // Back-to-back with in_valid held; in_state changes while BUSY
        out_ready = 1'b1;
        accept("b2b", {16{8'h63}});
        in_valid = 1'b1;
        in_state = {16{8'h7c}};
        wait_out(lat);
        chk("b2b_lat0",      128'(lat), 128'd4);
        chk("b2b_res0",      out_state, 128'd0);
        chk("b2b_in_ready",  {127'd0, in_ready}, 128'd1);
        step();
        in_valid = 1'b0;
        chk("b2b_rebusy",    {127'd0, busy},      128'd1);
        chk("b2b_valid_low", {127'd0, out_valid}, 128'd0);
        wait_out(lat);
        chk("b2b_lat1", 128'(lat), 128'd4);
        chk("b2b_res1", out_state, {16{8'h01}});
        step();
        out_ready = 1'b0;
        chk("b2b_idle", {127'd0, in_ready}, 128'd1);

        // Reset at BUSY cycle 2 discards the in-flight state
        accept("rstbusy", {16{8'h11}});
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("rstbusy_in_ready",  {127'd0, in_ready}, 128'd1);
        chk("rstbusy_busy",      {127'd0, busy},     128'd0);
        chk("rstbusy_out_state", out_state,          128'd0);
        bad = 1'b0;
        for (int c = 0; c < 2; c++) begin
            step();
            if (out_valid) bad = 1'b1;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            if (out_valid) bad = 1'b1;
        end
        chk("rstbusy_no_output", {127'd0, bad}, 128'd0);
        accept("after_rst", KV_IN);
        wait_out(lat);
        chk("after_rst_latency", 128'(lat), 128'd4);
        chk("after_rst_result",  out_state, KV_EXP);
        pop();

        // Exhaustive: feed forward S-box outputs, expect the original bytes
        for (int t = 0; t < 16; t++) begin
            s = '0;
            e = '0;
            for (int i = 0; i < 16; i++) begin
                s = {s[119:0], fwd[8'(16 * t + i)]};
                e = {e[119:0], 8'(16 * t + i)};
            end
            accept($sformatf("exh%0d", t), s);
            wait_out(lat);
            chk($sformatf("exh%0d_result", t), out_state, e);
            pop();
        end

        // Round trip of the FIPS-197 plaintext at BPC=4 and the other widths
        accept("rt4", sub_fwd(PT));
        wait_out(lat);
        chk("rt4_latency", 128'(lat), 128'd4);
        chk("rt4_result",  out_state, PT);
        pop();

        rt_exp = '{16, 8, 2, 1};
        for (int k = 0; k < 4; k++) begin
            rt_lat[k] = 0;
            chk($sformatf("rt_bpcidx%0d_ready", k), {127'd0, rt_rdy[k]}, 128'd1);
        end
        rt_state = sub_fwd(PT);
        rt_valid = 1'b1;
        step();
        rt_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (rt_exp[k] > 1) chk($sformatf("rt_bpcidx%0d_busy", k), {127'd0, rt_busy[k]}, 128'd1);
        end
        for (int c = 1; c <= 40; c++) begin
            for (int k = 0; k < 4; k++) begin
                if (rt_ov[k] && rt_lat[k] == 0) rt_lat[k] = c - 1;
            end
            if (rt_lat[0] != 0 && rt_lat[1] != 0 && rt_lat[2] != 0 && rt_lat[3] != 0) break;
            step();
        end
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rt_bpcidx%0d_latency", k), 128'(rt_lat[k]), 128'(rt_exp[k]));
            chk($sformatf("rt_bpcidx%0d_result", k), rt_os[k], PT);
        end
        rt_ordy = 1'b1;
        step();
        rt_ordy = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
